// File: rtl/full_adder_reg.sv
// full_adder_reg: WIDTH-bit ripple-carry adder built from 1-bit full-adder cells,
// with the sum and carry-out held in flops that reset asynchronously.
module full_adder_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    assign w_c[0] = c;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s  <= '0;
            r_co <= 1'b0;
        end else begin
            r_s  <= w_s;
            r_co <= w_c[WIDTH];
        end
    end
    assign s  = r_s;
    assign co = r_co;
endmodule

// File: tb/tb_full_adder_reg.sv
// tb_full_adder_reg: checks a 1-bit and an 8-bit instance against an arithmetic
// reference every cycle, plus literal expectations for the corner cases.
module tb_full_adder_reg;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       s1, co1;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic [7:0] s8;
    logic       co8;
    logic [1:0] m1 = '0;
    logic [8:0] m8 = '0;
    int         vecs = 0;
    int         errs = 0;
    bit         done = 1'b0;
    logic [1:0] tbl [8];

    full_adder_reg #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .s(s1), .co(co1));
    full_adder_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .s(s8), .co(co8));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: outputs are last sampled a+b+c, or zero while in reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 = '0;
            m8 = '0;
        end else begin
            m1 = 2'(a1) + 2'(b1) + 2'(c1);
            m8 = 9'(a8) + 9'(b8) + 9'(c8);
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("model_w1", {63'b0, co1, s1} >> 0, 64'(m1));
            check("model_w8", 64'({co8, s8}), 64'(m8));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {s,co} expected for (a,b,c) = 000..111
        tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        repeat (2) @(posedge clk);
        #1;
        check("reset_w1", 64'({s1, co1}), 64'd0);
        check("reset_w8", 64'({co8, s8}), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            {a1, b1, c1} = 3'(k);
            {a8, b8, c8} = {8'($urandom), 8'($urandom), 1'($urandom)};
            tick();
            check($sformatf("sweep_%0d%0d%0d", a1, b1, c1), 64'({s1, co1}), 64'(tbl[k]));
            repeat (9) tick();
        end
        {a1, b1, c1} = 3'b111;
        repeat (2) tick();
        check("pre_reset", 64'({s1, co1}), 64'b11);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_reset", 64'({s1, co1}), 64'b00);
        tick();
        check("held_reset", 64'({s1, co1}), 64'b00);
        #2 rst = 1'b0;
        tick();
        check("post_reset", 64'({s1, co1}), 64'b11);
        {a1, b1, c1} = 3'b000;
        tick();
        check("lat_start", 64'({s1, co1}), 64'b00);
        {a1, b1, c1} = 3'b111;
        #3 check("lat_hold", 64'({s1, co1}), 64'b00);
        tick();
        check("lat_update", 64'({s1, co1}), 64'b11);
        {a8, b8, c8} = {8'hFF, 8'h00, 1'b1};
        tick();
        check("wrap_w8", 64'({co8, s8}), 64'h100);
        {a8, b8, c8} = {8'hFF, 8'hFF, 1'b1};
        tick();
        check("allones_w8", 64'({co8, s8}), 64'h1FF);
        {a8, b8, c8} = '0;
        tick();
        check("zero_w8", 64'({co8, s8}), 64'h000);
        for (int n = 0; n < 1000; n++) begin
            {a8, b8, c8} = {8'($urandom), 8'($urandom), 1'($urandom)};
            {a1, b1, c1} = 3'($urandom);
            tick();
        end
        @(negedge clk);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
